// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch front end: FSM state encoding
// and prefetch queue depth.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FULL  = 2'd3
  } fetchState;

  localparam int FETCH_QDEPTH = 2;
  localparam int COUNT_BITS   = $clog2(FETCH_QDEPTH + 1);

endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO holding {instruction, address} entries; slot 0 is the head.
// Unoccupied slots are kept at zero so the head reads 0 whenever the queue is empty.
module fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter int entryWidth = 24
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [entryWidth-1:0] pushData,
  output logic [COUNT_BITS-1:0] count,
  output logic                  headValid,
  output logic [entryWidth-1:0] headData
);

  localparam logic [COUNT_BITS-1:0] DEPTH = COUNT_BITS'(FETCH_QDEPTH);

  logic [entryWidth-1:0] slotQ [FETCH_QDEPTH];
  logic [COUNT_BITS-1:0] countReg, countNext, countAfterPop;
  logic                  doPop, doPush;

  always_comb begin
    doPop         = pop && (countReg != '0);
    doPush        = push && ((countReg < DEPTH) || doPop);
    countAfterPop = countReg - COUNT_BITS'(doPop);
    countNext     = flush ? '0 : countAfterPop + COUNT_BITS'(doPush);
  end

  // A pop shifts every slot toward the head; a push lands just past the survivors.
  for (genvar gi = 0; gi < FETCH_QDEPTH; gi++) begin : gSlot
    logic [entryWidth-1:0] slotReg, slotNext, shifted;

    if (gi + 1 < FETCH_QDEPTH) begin : gShift
      assign shifted = doPop ? slotQ[gi+1] : slotReg;
    end else begin : gLast
      assign shifted = doPop ? '0 : slotReg;
    end

    always_comb begin
      slotNext = shifted;
      if (flush) begin
        slotNext = '0;
      end else if (doPush && (countAfterPop == COUNT_BITS'(gi))) begin
        slotNext = pushData;
      end
    end

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        slotReg <= '0;
      end else begin
        slotReg <= slotNext;
      end
    end

    assign slotQ[gi] = slotReg;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      countReg <= '0;
    end else begin
      countReg <= countNext;
    end
  end

  assign count     = countReg;
  assign headValid = (countReg != '0);
  assign headData  = slotQ[0];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: walks the PC through the program RAM, captures
// returned words into a 2-entry queue and hands them to decode; redirect flushes.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                width       = 16,
  parameter int                length      = 8,
  parameter logic [length-1:0] resetVector = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  output logic              readEnable,
  output logic [length-1:0] readAddr,
  input  logic              dataReady,
  input  logic [width-1:0]  readData,
  input  logic              redirect,
  input  logic [length-1:0] redirectAddr,
  output logic              instrValid,
  output logic [width-1:0]  instr,
  output logic [length-1:0] instrAddr,
  input  logic              instrTaken
);

  localparam int                    ENTRY_W = width + length;
  localparam logic [COUNT_BITS-1:0] DEPTH   = COUNT_BITS'(FETCH_QDEPTH);

  fetchState             stateReg, stateNext;
  logic [length-1:0]     pcReg, pcNext;
  logic [COUNT_BITS-1:0] count, countAfter;
  logic                  headValid;
  logic [ENTRY_W-1:0]    headData;
  logic                  popNow, capture;

  always_comb begin
    popNow     = headValid && instrTaken && !redirect;
    // Only WAIT may capture: in ISSUE the RAM has not yet sampled the current PC.
    capture    = (stateReg == WAIT) && dataReady && !redirect && ((count < DEPTH) || popNow);
    countAfter = count - COUNT_BITS'(popNow) + COUNT_BITS'(capture);
    stateNext  = stateReg;
    pcNext     = pcReg;

    if (redirect) begin
      pcNext    = redirectAddr;
      stateNext = run ? ISSUE : IDLE;
    end else begin
      case (stateReg)
        IDLE:    if (run) stateNext = ISSUE;
        ISSUE:   stateNext = run ? WAIT : IDLE;
        WAIT: begin
          if (capture) begin
            pcNext = pcReg + length'(1);
            if (!run)                    stateNext = IDLE;
            else if (countAfter == DEPTH) stateNext = FULL;
            else                          stateNext = ISSUE;
          end
        end
        FULL: begin
          if (!run)                    stateNext = IDLE;
          else if (countAfter < DEPTH) stateNext = ISSUE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stateReg   <= IDLE;
      pcReg      <= resetVector;
      readEnable <= 1'b0;
      readAddr   <= '0;
    end else begin
      stateReg   <= stateNext;
      pcReg      <= pcNext;
      readEnable <= (stateNext == ISSUE) || (stateNext == WAIT);
      readAddr   <= pcNext;
    end
  end

  fetch_queue #(
    .entryWidth(ENTRY_W)
  ) queue (
    .clk      (clk),
    .clr      (clr),
    .push     (capture),
    .pop      (popNow),
    .flush    (redirect),
    .pushData ({readData, pcReg}),
    .count    (count),
    .headValid(headValid),
    .headData (headData)
  );

  assign instrValid = headValid;
  assign instr      = headData[ENTRY_W-1:length];
  assign instrAddr  = headData[length-1:0];

endmodule
